// File: rtl/shot_pool_pkg.sv
// shot_pool_pkg: shared FSM encoding, screen constants and parameter defaults for the bullet pool
package shot_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_SPAWN = 2'd2;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int DEF_NUM_SHOTS = 8;
    localparam int DEF_SHOT_W    = 4;
    localparam int DEF_SHOT_H    = 8;
    localparam int DEF_SPEED     = 4;
    localparam int DEF_START_Y   = 440;
    localparam int DEF_X_OFFSET  = 14;
    localparam int DEF_COOLDOWN  = 6;
    localparam int OVL_W         = 12;
endpackage

// File: rtl/shot_pool_if.sv
// shot_pool_if: frame/gun/target/pixel inputs and draw/status outputs of the bullet pool
interface shot_pool_if
    import shot_pkg::*;
#(
    parameter int NUM_SHOTS = DEF_NUM_SHOTS
);
    logic                 frame_tick;
    logic                 fire;
    logic [9:0]           gun_x;
    logic [10:0]          target_x;
    logic [9:0]           target_y;
    logic [7:0]           target_w;
    logic [7:0]           target_h;
    logic                 target_valid;
    logic [9:0]           hcount;
    logic [9:0]           vcount;
    logic                 shot_draw;
    logic                 hit;
    logic [7:0]           hit_count;
    logic [NUM_SHOTS-1:0] active_mask;
    logic                 pool_full;

    modport master (
        output frame_tick, fire, gun_x, target_x, target_y, target_w, target_h,
               target_valid, hcount, vcount,
        input  shot_draw, hit, hit_count, active_mask, pool_full
    );

    modport slave (
        input  frame_tick, fire, gun_x, target_x, target_y, target_w, target_h,
               target_valid, hcount, vcount,
        output shot_draw, hit, hit_count, active_mask, pool_full
    );
endinterface

// File: rtl/shot_pool_free_slot_finder.sv
// free_slot_finder: lowest-index dead slot of the pool plus a found flag
module free_slot_finder #(
    parameter int N = 8
) (
    input  logic [N-1:0]         mask_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);
    localparam int IW = $clog2(N);

    // scan downwards so the lowest free index is the last one written
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (!mask_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
    end
endmodule

// File: rtl/shot_pool.sv
// shot_pool: bullet slot pool (spawn, per-frame move, duck hit test, pixel draw); `define SHOT_POOL_AUTOFIRE_EN makes a held fire button re-arm every frame
module shot_pool
    import shot_pkg::*;
#(
    parameter int NUM_SHOTS = DEF_NUM_SHOTS,
    parameter int SHOT_W    = DEF_SHOT_W,
    parameter int SHOT_H    = DEF_SHOT_H,
    parameter int SPEED     = DEF_SPEED,
    parameter int START_Y   = DEF_START_Y,
    parameter int X_OFFSET  = DEF_X_OFFSET,
    parameter int COOLDOWN  = DEF_COOLDOWN
) (
    input logic        vga_clk,
    input logic        reset,
    shot_pool_if.slave bus
);
    localparam int IW = $clog2(NUM_SHOTS);

    logic [1:0]           state_q;
    logic [IW-1:0]        idx_q;
    logic [NUM_SHOTS-1:0] live_q, mask_q;
    logic [10:0]          x_q [NUM_SHOTS];
    logic [9:0]           y_q [NUM_SHOTS];
    logic [7:0]           cd_q, hit_count_q;
    logic                 cd_ok_q, pend_q, frame_hit_q, hit_q, full_q, draw_q;
    logic [2:0]           fire_q;
    logic                 fire_set, overlap, draw_d, free_found;
    logic [IW-1:0]        free_idx;
    logic [10:0]          cur_x;
    logic [9:0]           cur_y, y_new;
    logic [OVL_W-1:0]     bx, ny, tx, ty;

    free_slot_finder #(.N(NUM_SHOTS)) u_free (
        .mask_i (live_q),
        .idx_o  (free_idx),
        .found_o(free_found)
    );

`ifdef SHOT_POOL_AUTOFIRE_EN
    assign fire_set = fire_q[1];
`else
    assign fire_set = fire_q[1] & ~fire_q[2];
`endif

    assign cur_x   = x_q[idx_q];
    assign cur_y   = y_q[idx_q];
    assign y_new   = cur_y - 10'(SPEED);
    assign bx      = OVL_W'(cur_x);
    assign ny      = OVL_W'(y_new);
    assign tx      = OVL_W'(bus.target_x);
    assign ty      = OVL_W'(bus.target_y);
    assign overlap = (bx < tx + OVL_W'(bus.target_w)) && (bx + OVL_W'(SHOT_W) > tx) &&
                     (ny < ty + OVL_W'(bus.target_h)) && (ny + OVL_W'(SHOT_H) > ty);

    // pixel lies inside any live bullet box
    always_comb begin
        draw_d = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++)
            if (live_q[i] &&
                OVL_W'(bus.hcount) >= OVL_W'(x_q[i]) && OVL_W'(bus.hcount) < OVL_W'(x_q[i]) + OVL_W'(SHOT_W) &&
                OVL_W'(bus.vcount) >= OVL_W'(y_q[i]) && OVL_W'(bus.vcount) < OVL_W'(y_q[i]) + OVL_W'(SHOT_H))
                draw_d = 1'b1;
    end

    // two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge vga_clk or negedge reset)
        if (!reset) fire_q <= '0;
        else        fire_q <= {fire_q[1:0], bus.fire};

    // frame FSM: move/test one slot per SCAN cycle, spawn and report hits in SPAWN
    // the cooldown gate is sampled at frame start, so a load of COOLDOWN blocks that many following frames
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            live_q      <= '0;
            cd_q        <= '0;
            cd_ok_q     <= 1'b0;
            pend_q      <= 1'b0;
            frame_hit_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_count_q <= '0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            hit_q  <= 1'b0;
            pend_q <= pend_q | fire_set;
            if (state_q == ST_IDLE && bus.frame_tick) begin
                state_q <= ST_SCAN;
                idx_q   <= '0;
                cd_ok_q <= cd_q == 8'd0;
                if (cd_q != 8'd0) cd_q <= cd_q - 8'd1;
            end else if (state_q == ST_SCAN) begin
                if (live_q[idx_q]) begin
                    y_q[idx_q] <= y_new;
                    if (cur_y < 10'(SPEED)) live_q[idx_q] <= 1'b0;
                    else if (bus.target_valid && overlap) begin
                        live_q[idx_q] <= 1'b0;
                        frame_hit_q   <= 1'b1;
                    end
                end
                idx_q <= idx_q + 1'b1;
                if (idx_q == IW'(NUM_SHOTS - 1)) state_q <= ST_SPAWN;
            end else if (state_q == ST_SPAWN) begin
                if (pend_q && cd_ok_q && free_found) begin
                    live_q[free_idx] <= 1'b1;
                    x_q[free_idx]    <= 11'(bus.gun_x) + 11'(X_OFFSET);
                    y_q[free_idx]    <= 10'(START_Y);
                    cd_q             <= 8'(COOLDOWN);
                    pend_q           <= fire_set;
                end
                hit_q       <= frame_hit_q;
                if (frame_hit_q && hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
                frame_hit_q <= 1'b0;
                state_q     <= ST_IDLE;
            end
        end
    end

    // registered status and draw outputs, one cycle behind slot state and pixel position
    always_ff @(posedge vga_clk or negedge reset)
        if (!reset) begin
            mask_q <= '0;
            full_q <= 1'b0;
            draw_q <= 1'b0;
        end else begin
            mask_q <= live_q;
            full_q <= &live_q;
            draw_q <= draw_d;
        end

    assign bus.shot_draw   = draw_q;
    assign bus.hit         = hit_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.active_mask = mask_q;
    assign bus.pool_full   = full_q;
endmodule

// File: tb/tb_shot_pool.sv
// tb_shot_pool: directed and randomized frame-level checks of shot_pool against a slot-array model
module tb_shot_pool;
    import shot_pkg::*;

    localparam int N  = DEF_NUM_SHOTS;
    localparam int W  = DEF_SHOT_W;
    localparam int H  = DEF_SHOT_H;
    localparam int SP = DEF_SPEED;
    localparam int SY = DEF_START_Y;
    localparam int XO = DEF_X_OFFSET;
    localparam int CD = DEF_COOLDOWN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shot_pool_if #(.NUM_SHOTS(N)) bus ();

    shot_pool #(
        .NUM_SHOTS(N), .SHOT_W(W), .SHOT_H(H), .SPEED(SP),
        .START_Y(SY), .X_OFFSET(XO), .COOLDOWN(CD)
    ) dut (
        .vga_clk(clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mx [N];
    int my [N];
    bit ml [N];
    int mcd, mhc;
    bit mpend;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mask_exp();
        int m = 0;
        for (int i = 0; i < N; i++) if (ml[i]) m |= 1 << i;
        return m;
    endfunction

    function automatic int draw_exp(input int h, input int v);
        for (int i = 0; i < N; i++)
            if (ml[i] && h >= mx[i] && h < mx[i] + W && v >= my[i] && v < my[i] + H) return 1;
        return 0;
    endfunction

    task automatic model_frame(output bit fh);
        bit ok;
        int f, tx, ty, tw, th;
        tx = int'(bus.target_x); ty = int'(bus.target_y);
        tw = int'(bus.target_w); th = int'(bus.target_h);
        ok = (mcd == 0);
        if (mcd > 0) mcd--;
        fh = 0;
        for (int i = 0; i < N; i++)
            if (ml[i]) begin
                if (my[i] < SP) ml[i] = 0;
                else begin
                    my[i] -= SP;
                    if (bus.target_valid && mx[i] < tx + tw && mx[i] + W > tx &&
                        my[i] < ty + th && my[i] + H > ty) begin
                        ml[i] = 0;
                        fh = 1;
                    end
                end
            end
        f = -1;
        for (int i = N - 1; i >= 0; i--) if (!ml[i]) f = i;
        if (mpend && ok && f >= 0) begin
            ml[f] = 1; mx[f] = int'(bus.gun_x) + XO; my[f] = SY;
            mcd = CD; mpend = 0;
        end
        if (fh && mhc < 255) mhc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.frame_tick = 0; bus.fire = 0; bus.gun_x = 0;
        bus.target_x = 0; bus.target_y = 0; bus.target_w = 0; bus.target_h = 0;
        bus.target_valid = 0; bus.hcount = 0; bus.vcount = 0;
        for (int i = 0; i < N; i++) begin ml[i] = 0; mx[i] = 0; my[i] = 0; end
        mcd = 0; mhc = 0; mpend = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fire_edge();
        @(negedge clk) bus.fire = 1;
        repeat (4) @(negedge clk);
        bus.fire = 0;
        repeat (4) @(negedge clk);
        mpend = 1;
    endtask

    task automatic frame(input string tag);
        bit fh;
        int hits = 0;
        @(negedge clk) bus.frame_tick = 1;
        @(negedge clk) bus.frame_tick = 0;
        repeat (N + 4) begin
            hits += int'(bus.hit);
            @(negedge clk);
        end
        model_frame(fh);
        check({tag, "_mask"}, int'(bus.active_mask), mask_exp());
        check({tag, "_full"}, int'(bus.pool_full), int'(mask_exp() == (1 << N) - 1));
        check({tag, "_hits"}, hits, int'(fh));
        check({tag, "_hcnt"}, int'(bus.hit_count), mhc);
    endtask

    task automatic pix(input string tag, input int h, input int v, input int exp);
        bus.hcount = 10'(h);
        bus.vcount = 10'(v);
        @(negedge clk);
        @(negedge clk);
        check(tag, int'(bus.shot_draw), exp);
    endtask

    initial begin
        int cnt, i;
        do_reset();
        check("rst_draw", int'(bus.shot_draw), 0);
        check("rst_hit", int'(bus.hit), 0);
        check("rst_hcnt", int'(bus.hit_count), 0);
        check("rst_mask", int'(bus.active_mask), 0);
        check("rst_full", int'(bus.pool_full), 0);

        // single shot
        bus.gun_x = 100;
        fire_edge();
        frame("ss0");
        check("ss_spawn", int'(bus.active_mask), 1);
        pix("ss_at_spawn", 114, 440, 1);
        repeat (3) frame("ss");
        pix("ss_in", 115, 430, 1);
        pix("ss_top", 114, 428, 1);
        pix("ss_right", 118, 430, 0);
        pix("ss_below", 115, 436, 0);
        pix("ss_above", 115, 427, 0);

        // collision on the first move
        do_reset();
        bus.gun_x = 100;
        bus.target_x = 110; bus.target_y = 420; bus.target_w = 30; bus.target_h = 20;
        bus.target_valid = 1;
        fire_edge();
        frame("col0");
        frame("col1");
        check("col_mask", int'(bus.active_mask), 0);
        check("col_hcnt", int'(bus.hit_count), 1);

        // two bullets hit in the same frame
        do_reset();
        bus.gun_x = 100;
        fire_edge();
        frame("dh1");
        fire_edge();
        repeat (7) frame("dh");
        check("dh_two_live", int'(bus.active_mask), 3);
        bus.target_x = 100; bus.target_y = 380; bus.target_w = 40; bus.target_h = 80;
        bus.target_valid = 1;
        frame("dh9");
        check("dh_mask", int'(bus.active_mask), 0);
        check("dh_hcnt", int'(bus.hit_count), 1);

        // fill the pool, leave one request pending, exit through the top
        do_reset();
        bus.gun_x = 100;
        for (int k = 0; k < 9; k++) begin
            fire_edge();
            repeat (7) frame("pf");
        end
        check("pf_mask", int'(bus.active_mask), 255);
        check("pf_full", int'(bus.pool_full), 1);
        repeat (48) frame("pf");
        pix("top_y0", 115, 3, 1);
        frame("pf112");
        pix("top_gone", 115, 3, 0);
        pix("top_nowrap", 115, 1021, 0);
        pix("pf_respawn", 115, 441, 1);
        check("pf_refill", int'(bus.active_mask), 255);

        // fire held for 20 frames
        do_reset();
        bus.gun_x = 200;
        bus.fire = 1;
        repeat (4) @(negedge clk);
        for (int f = 0; f < 20; f++) begin
`ifdef SHOT_POOL_AUTOFIRE_EN
            mpend = 1;
`else
            if (f == 0) mpend = 1;
`endif
            frame("hold");
        end
        bus.fire = 0;
        cnt = $countones(bus.active_mask);
`ifdef SHOT_POOL_AUTOFIRE_EN
        check("hold_spawns", cnt, 3);
`else
        check("hold_spawns", cnt, 1);
`endif

        // randomized frames
        do_reset();
        for (int f = 0; f < 200; f++) begin
            bus.gun_x = 10'($urandom_range(0, 600));
            bus.target_x = 11'($urandom_range(0, 640));
            bus.target_y = 10'($urandom_range(0, 479));
            bus.target_w = 8'($urandom_range(8, 80));
            bus.target_h = 8'($urandom_range(8, 80));
            bus.target_valid = ($urandom % 3) != 0;
            if ($urandom % 2) fire_edge();
            frame("rnd");
            i = $urandom % N;
            if (ml[i]) pix("rnd_in", mx[i] + $urandom % W, my[i] + $urandom % H, 1);
            begin
                int h = $urandom_range(0, 639);
                int v = $urandom_range(0, 479);
                pix("rnd_px", h, v, draw_exp(h, v));
            end
        end

        // asynchronous reset in the middle of SCAN
        bus.target_valid = 0;
        fire_edge();
        @(negedge clk) bus.frame_tick = 1;
        @(negedge clk) bus.frame_tick = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ar_mask", int'(bus.active_mask), 0);
        check("ar_hcnt", int'(bus.hit_count), 0);
        check("ar_full", int'(bus.pool_full), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
